// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-word mode-0 SPI master with optional burst chip-select hold
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  keep_cs,
  input  logic                  end_burst,
  input  logic [DATA_WIDTH-1:0] data_to_send,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_received,
  output logic                  cs,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int HW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [HW-1:0] HC_MAX  = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, CHAIN} state_t;

  state_t                state, state_n;
  logic [HW-1:0]         hc, hc_n, hc_step;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] tx_sr, tx_n, rx_sr, rx_n, drx_nxt;
  logic                  keep_r, keep_n;
  logic                  cs_nxt, sck_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic                  miso_s1, miso_s2;
  logic                  hc_last, load;

  assign hc_last = (hc == HC_MAX);
  assign hc_step = hc_last ? '0 : hc + HW'(1);
  assign load    = start && ((state == IDLE) || (state == CHAIN));

  always_comb begin
    state_n  = state;
    hc_n     = '0;
    bit_n    = bit_cnt;
    tx_n     = tx_sr;
    rx_n     = rx_sr;
    keep_n   = keep_r;
    cs_nxt   = cs;
    sck_nxt  = sck;
    mosi_nxt = mosi;
    busy_nxt = busy;
    done_nxt = 1'b0;
    drx_nxt  = data_received;
    case (state)
      IDLE: begin
        cs_nxt   = 1'b1;
        sck_nxt  = 1'b0;
        mosi_nxt = 1'b0;
        busy_nxt = 1'b0;
      end
      SETUP: begin
        hc_n = hc_step;
        if (hc_last) begin
          sck_nxt = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        hc_n = hc_step;
        if (hc_last) begin
          if (sck) begin
            // Capturing at the end of the high phase cancels the synchroniser
            // latency, so rx holds the miso level present at the sck rise.
            sck_nxt = 1'b0;
            rx_n    = {rx_sr[DATA_WIDTH-2:0], miso_s2};
            if (bit_cnt != BIT_MAX) begin
              mosi_nxt = tx_sr[DATA_WIDTH-1];
              tx_n     = tx_sr << 1;
            end
          end else if (bit_cnt == BIT_MAX) begin
            done_nxt = 1'b1;
            drx_nxt  = rx_sr;
            mosi_nxt = 1'b0;
            state_n  = HOLD;
          end else begin
            sck_nxt = 1'b1;
            bit_n   = bit_cnt + BW'(1);
          end
        end
      end
      HOLD: begin
        hc_n = hc_step;
        if (hc_last) begin
          busy_nxt = 1'b0;
          if (keep_r) begin
            state_n = CHAIN;
          end else begin
            cs_nxt  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      CHAIN: begin
        cs_nxt   = 1'b0;
        sck_nxt  = 1'b0;
        mosi_nxt = 1'b0;
        busy_nxt = 1'b0;
        if (!start && end_burst) begin
          cs_nxt  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A start in CHAIN takes priority over end_burst and keeps cs low.
    if (load) begin
      tx_n     = {data_to_send[DATA_WIDTH-2:0], 1'b0};
      keep_n   = keep_cs;
      cs_nxt   = 1'b0;
      mosi_nxt = data_to_send[DATA_WIDTH-1];
      busy_nxt = 1'b1;
      bit_n    = '0;
      hc_n     = '0;
      state_n  = SETUP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc            <= '0;
      bit_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      keep_r        <= 1'b0;
      cs            <= 1'b1;
      sck           <= 1'b0;
      mosi          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      data_received <= '0;
      miso_s1       <= 1'b0;
      miso_s2       <= 1'b0;
    end else begin
      hc            <= hc_n;
      bit_cnt       <= bit_n;
      tx_sr         <= tx_n;
      rx_sr         <= rx_n;
      keep_r        <= keep_n;
      cs            <= cs_nxt;
      sck           <= sck_nxt;
      mosi          <= mosi_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      data_received <= drx_nxt;
      miso_s1       <= miso;
      miso_s2       <= miso_s1;
    end
  end

endmodule
